// File: rtl/lct_l1a_match.sv
// L1A-to-LCT matcher with event counter and ALCT/TMB data-available supervisors.
// Keeps a per-channel LCT history and flags missing, late or unexpected DAV pulses.
module lct_l1a_match #(
  parameter int LCT_L1A_DLY = 100,
  parameter int WIN         = 3,
  parameter int HIST_DEPTH  = 128,
  parameter int DAV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        l1a,
  input  logic [7:0]  lct,
  input  logic        alct_dav,
  input  logic        tmb_dav,
  output logic        l1a_out,
  output logic [7:0]  l1a_match,
  output logic [23:0] l1a_cnt,
  output logic        alct_timeout,
  output logic        tmb_timeout,
  output logic        alct_unexp,
  output logic        tmb_unexp,
  output logic        alct_overlap,
  output logic        tmb_overlap
);

  localparam int H  = WIN / 2;
  localparam int LO = LCT_L1A_DLY - H - 1;
  localparam int HI = LCT_L1A_DLY + H - 1;
  localparam logic [7:0] TMR_LAST = 8'(DAV_TIMEOUT - 1);

  function automatic logic [HIST_DEPTH-1:0] win_mask();
    logic [HIST_DEPTH-1:0] m;
    m = '0;
    for (int k = LO; k <= HI; k++) m[k] = 1'b1;
    return m;
  endfunction

  localparam logic [HIST_DEPTH-1:0] WIN_MASK = win_mask();

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} sup_state_t;

  logic [HIST_DEPTH-1:0] hist_p0 [8];
  logic [7:0]            hit_p0;

  // Stage 0: history shift; bit k holds the LCT seen k+1 cycles ago
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst) hist_p0[i] <= '0;
      else     hist_p0[i] <= {hist_p0[i][HIST_DEPTH-2:0], lct[i]};
    end
  end

  always_comb begin
    hit_p0 = '0;
    for (int i = 0; i < 8; i++) hit_p0[i] = |(hist_p0[i] & WIN_MASK);
  end

  // Stage 1: registered L1A strobe, match vector and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      l1a_out   <= 1'b0;
      l1a_match <= '0;
      l1a_cnt   <= '0;
    end else begin
      l1a_out   <= l1a;
      l1a_match <= l1a ? hit_p0 : 8'h00;
      l1a_cnt   <= l1a_cnt + 24'(l1a);
    end
  end

  logic [1:0] dav;
  logic [1:0] unexp_d, overlap_d, timeout_d;

  assign dav = {tmb_dav, alct_dav};

  for (genvar s = 0; s < 2; s++) begin : g_sup
    sup_state_t state, state_nx;
    logic [7:0] timer, timer_nx;
    logic       unexp, overlap, timeout;

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        state <= state_nx;
        timer <= timer_nx;
      end
    end

    // A new L1A always wins: it restarts the wait whether or not a DAV closes the old one
    always_comb begin
      state_nx = state;
      timer_nx = timer;
      if (state == IDLE) begin
        if (l1a) begin
          state_nx = WAIT;
          timer_nx = '0;
        end
      end else begin
        if (l1a) begin
          timer_nx = '0;
        end else if (dav[s] || timer == TMR_LAST) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 8'd1;
        end
      end
    end

    always_comb begin
      unexp   = (state == IDLE) && dav[s];
      overlap = (state == WAIT) && l1a && !dav[s];
      timeout = (state == WAIT) && !l1a && !dav[s] && (timer == TMR_LAST);
    end

    assign unexp_d[s]   = unexp;
    assign overlap_d[s] = overlap;
    assign timeout_d[s] = timeout;
  end

  // Stage 1: registered supervisor flag pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      alct_timeout <= 1'b0;
      tmb_timeout  <= 1'b0;
      alct_unexp   <= 1'b0;
      tmb_unexp    <= 1'b0;
      alct_overlap <= 1'b0;
      tmb_overlap  <= 1'b0;
    end else begin
      alct_timeout <= timeout_d[0];
      tmb_timeout  <= timeout_d[1];
      alct_unexp   <= unexp_d[0];
      tmb_unexp    <= unexp_d[1];
      alct_overlap <= overlap_d[0];
      tmb_overlap  <= overlap_d[1];
    end
  end

endmodule

// File: tb/tb_lct_l1a_match.sv
// Bench for lct_l1a_match: directed scenarios plus random traffic, checked every
// cycle against a time-stamped behavioural model.
module tb_lct_l1a_match;
  localparam int D    = 100;
  localparam int WIN  = 3;
  localparam int H    = WIN / 2;
  localparam int TO   = 64;
  localparam int MAXC = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        l1a = 1'b0;
  logic [7:0]  lct = 8'h00;
  logic        alct_dav = 1'b0;
  logic        tmb_dav = 1'b0;
  logic        l1a_out;
  logic [7:0]  l1a_match;
  logic [23:0] l1a_cnt;
  logic        alct_timeout, tmb_timeout, alct_unexp, tmb_unexp, alct_overlap, tmb_overlap;

  always #5 clk = ~clk;

  lct_l1a_match #(.LCT_L1A_DLY(D), .WIN(WIN), .HIST_DEPTH(128), .DAV_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .l1a(l1a), .lct(lct), .alct_dav(alct_dav), .tmb_dav(tmb_dav),
    .l1a_out(l1a_out), .l1a_match(l1a_match), .l1a_cnt(l1a_cnt),
    .alct_timeout(alct_timeout), .tmb_timeout(tmb_timeout),
    .alct_unexp(alct_unexp), .tmb_unexp(tmb_unexp),
    .alct_overlap(alct_overlap), .tmb_overlap(tmb_overlap)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rst = 0;

  logic [7:0]  lct_log [MAXC];
  logic        e_l1a_out;
  logic [7:0]  e_match;
  logic [23:0] e_cnt;
  logic [1:0]  e_to, e_ux, e_ov;
  bit          pend [2];
  int          t0 [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: an absolute-time log of LCTs and, per supervisor, the time of the open L1A.
  task automatic model(input logic r, input logic a, input logic [7:0] l,
                       input logic ad, input logic td);
    logic [1:0] dv;
    logic [7:0] w;
    dv = {td, ad};
    w  = 8'h00;
    if (r) begin
      e_l1a_out = 0; e_match = 0; e_cnt = 0;
      e_to = 0; e_ux = 0; e_ov = 0;
      pend[0] = 0; pend[1] = 0;
      last_rst = cyc;
      lct_log[cyc] = 8'h00;
    end else begin
      for (int j = cyc - D - H; j <= cyc - D + H; j++)
        if (j > last_rst && j >= 0) w |= lct_log[j];
      e_l1a_out = a;
      e_match   = a ? w : 8'h00;
      e_cnt     = e_cnt + 24'(a);
      lct_log[cyc] = l;
      for (int s = 0; s < 2; s++) begin
        e_ux[s] = dv[s] && !pend[s];
        e_ov[s] = a && pend[s] && !dv[s];
        e_to[s] = pend[s] && !dv[s] && !a && (cyc - t0[s] == TO);
        if (a) begin
          pend[s] = 1; t0[s] = cyc;
        end else if (dv[s] || e_to[s]) begin
          pend[s] = 0;
        end
      end
    end
  endtask

  task automatic compare();
    chk("l1a_out", 32'(l1a_out), 32'(e_l1a_out));
    chk("l1a_match", 32'(l1a_match), 32'(e_match));
    chk("l1a_cnt", 32'(l1a_cnt), 32'(e_cnt));
    chk("alct_timeout", 32'(alct_timeout), 32'(e_to[0]));
    chk("tmb_timeout", 32'(tmb_timeout), 32'(e_to[1]));
    chk("alct_unexp", 32'(alct_unexp), 32'(e_ux[0]));
    chk("tmb_unexp", 32'(tmb_unexp), 32'(e_ux[1]));
    chk("alct_overlap", 32'(alct_overlap), 32'(e_ov[0]));
    chk("tmb_overlap", 32'(tmb_overlap), 32'(e_ov[1]));
  endtask

  task automatic step(input logic r, input logic a, input logic [7:0] l,
                      input logic ad, input logic td);
    rst = r; l1a = a; lct = l; alct_dav = ad; tmb_dav = td;
    @(posedge clk);
    model(r, a, l, ad, td);
    @(negedge clk);
    compare();
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_l1a_out"}, 32'(l1a_out), 0);
    chk({tag, "_match"}, 32'(l1a_match), 0);
    chk({tag, "_cnt"}, 32'(l1a_cnt), 0);
    chk({tag, "_flags"}, 32'({alct_timeout, tmb_timeout, alct_unexp, tmb_unexp,
                              alct_overlap, tmb_overlap}), 0);
  endtask

  task automatic win_run(input int off, input logic [7:0] exp);
    step(1'b0, 1'b0, 8'h08, 1'b0, 1'b0);
    idle(off - 1);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk($sformatf("win_off%0d", off), 32'(l1a_match), 32'(exp));
    idle(150);
  endtask

  task automatic rand_phase(input int n, input int l1a_rate, input int dav_rate, input int rst_rate);
    logic a, ad, td, r;
    logic [7:0] l;
    for (int i = 0; i < n; i++) begin
      r  = ($urandom_range(0, rst_rate - 1) == 0);
      a  = ($urandom_range(0, l1a_rate - 1) == 0);
      ad = ($urandom_range(0, dav_rate - 1) == 0);
      td = ($urandom_range(0, dav_rate - 1) == 0);
      l  = 8'($urandom & $urandom & $urandom & $urandom);
      step(r, a, l, ad, td);
    end
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) lct_log[i] = 8'h00;

    // Reset state
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_all_zero("reset");
    idle(10);

    // Basic match: lct 0x05, L1A 100 cycles later
    step(1'b0, 1'b0, 8'h05, 1'b0, 1'b0);
    idle(99);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("basic_l1a_out", 32'(l1a_out), 1);
    chk("basic_match", 32'(l1a_match), 32'h05);
    chk("basic_cnt", 32'(l1a_cnt), 1);
    idle(150);

    // Window edges
    win_run(99, 8'h08);
    win_run(101, 8'h08);
    win_run(98, 8'h00);
    win_run(102, 8'h00);

    // ALCT DAV accepted, TMB times out DAV_TIMEOUT+1 after the L1A
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    idle(29);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("dav_ok_alct_unexp", 32'(alct_unexp), 0);
    idle(33);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("tmb_timeout_hit", 32'(tmb_timeout), 1);
    chk("alct_timeout_quiet", 32'(alct_timeout), 0);
    idle(5);

    // Unexpected DAV, then overlap and re-timed timeout
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("tmb_unexp", 32'(tmb_unexp), 1);
    chk("alct_unexp_quiet", 32'(alct_unexp), 0);
    idle(3);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    idle(9);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("alct_overlap", 32'(alct_overlap), 1);
    chk("tmb_overlap", 32'(tmb_overlap), 1);
    idle(53);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("old_timeout_suppressed", 32'(tmb_timeout), 0);
    idle(9);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("retimed_alct_timeout", 32'(alct_timeout), 1);
    chk("retimed_tmb_timeout", 32'(tmb_timeout), 1);
    idle(3);

    // Counter wrap from a preloaded value
    force dut.l1a_cnt = 24'hFFFFFE;
    #1;
    release dut.l1a_cnt;
    e_cnt = 24'hFFFFFE;
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("wrap_cnt0", 32'(l1a_cnt), 32'hFFFFFF);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("wrap_cnt1", 32'(l1a_cnt), 32'h000000);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("wrap_cnt2", 32'(l1a_cnt), 32'h000001);
    idle(70);

    // Reset mid-wait discards pending DAVs and clears history
    step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    idle(4);
    repeat (2) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_all_zero("midreset");
    idle(57);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("no_timeout_after_rst", 32'({alct_timeout, tmb_timeout}), 0);
    idle(30);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("post_rst_match", 32'(l1a_match), 0);
    chk("post_rst_cnt", 32'(l1a_cnt), 1);
    idle(80);

    // Randomized traffic: dense L1As, then sparse L1As with DAV traffic
    rand_phase(1500, 8, 40, 800);
    rand_phase(3000, 150, 50, 2000);
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lct_l1a_match.md
# lct_l1a_match

Consumes the per-cycle trigger stream driven into the ODMB (`l1a`, `lct[7:0]`, `alct_dav`, `tmb_dav`) and produces the per-channel L1A match vector and an L1A event counter for the downstream DCFEB/OTMB readout control. It also supervises the ALCT and TMB data-available handshakes that must follow each L1A, flagging timeouts and protocol violations. It sits directly after the trigger/command source and before the readout FIFO control.

## Interface
- `LCT_L1A_DLY`, 100: nominal cycles from an LCT to its L1A; range 2..(`HIST_DEPTH`-`WIN`).
- `WIN`, 3: match window width in cycles; must be odd, ≥1.
- `HIST_DEPTH`, 128: LCT history depth per channel; must be ≥ `LCT_L1A_DLY`+`WIN`/2+1.
- `DAV_TIMEOUT`, 64: maximum cycles from L1A to the matching `alct_dav`/`tmb_dav`; must be ≥1.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `l1a`  in  1  Level-1 accept, single-cycle pulse.
- `lct`  in  8  per-channel LCT pulses; bit i = channel i.
- `alct_dav`  in  1  ALCT data-available pulse.
- `tmb_dav`  in  1  TMB data-available pulse.
- `l1a_out`  out  1  registered L1A strobe; qualifies `l1a_match`.
- `l1a_match`  out  8  channels with an LCT inside the window for this L1A.
- `l1a_cnt`  out  24  L1A counter, value including the current L1A.
- `alct_timeout`, `tmb_timeout`  out  1  pulse: expected DAV not received in time.
- `alct_unexp`, `tmb_unexp`  out  1  pulse: DAV received with no L1A outstanding.
- `alct_overlap`, `tmb_overlap`  out  1  pulse: new L1A while the previous DAV is still pending.

## Operation
- History: per channel, shift register `hist[i][0..HIST_DEPTH-1]`. Each cycle, `hist[i][0]` ← `lct[i]` and `hist[i][k]` ← `hist[i][k-1]`. `hist[i][k]` is therefore the LCT seen k+1 cycles ago.
- Match: with H=`WIN`/2 (integer division), an L1A at cycle T matches channel i if `lct[i]` was high at any cycle in [T-`LCT_L1A_DLY`-H, T-`LCT_L1A_DLY`+H]. These are indices `LCT_L1A_DLY`-H-1 .. `LCT_L1A_DLY`+H-1 of the history as sampled at T.
- An LCT arriving in the same cycle as `l1a` is never matched.
- Multiple LCTs in the window collapse to a single match bit.
- Counter: `l1a_cnt` increments by 1 on each `l1a` and wraps from 0xFFFFFF to 0x000000 with no flag.
- DAV supervisors: two identical, independent FSMs (ALCT, TMB), each with states IDLE and WAIT and an 8-bit timer.
  - IDLE, `l1a`=1 → WAIT, timer←0.
  - IDLE, dav=1 → unexp pulse. If `l1a` is also high in that cycle, still go to WAIT.
  - WAIT, dav=1, `l1a`=0 → IDLE.
  - WAIT, `l1a`=1, dav=0 → overlap pulse, stay in WAIT, timer←0.
  - WAIT, dav=1 and `l1a`=1 → the dav closes the old L1A; stay in WAIT, timer←0; no flag.
  - WAIT, no dav and timer = `DAV_TIMEOUT`-1 → timeout pulse, IDLE. If `l1a` is high in that cycle, the overlap rule applies instead (no timeout, timer←0).
  - Otherwise in WAIT: timer increments.

## Timing
- Reset values: all outputs 0, history cleared, `l1a_cnt`=0, both FSMs IDLE, timers 0.
- Reset applied mid-wait discards the pending DAV with no flag.
- `l1a` at edge T produces `l1a_out`=1, `l1a_match`, and the updated `l1a_cnt` at edge T+1. Latency is 1 cycle.
- `l1a_match` is 0 whenever `l1a_out`=0.
- Back-to-back L1As on consecutive cycles are each matched and counted independently.
- A DAV arriving k cycles after L1A (k = 1..`DAV_TIMEOUT`) is accepted. With no DAV, the timeout pulse is registered `DAV_TIMEOUT`+1 cycles after the L1A.
- All flag outputs are registered, one-cycle pulses, appearing 1 cycle after the causing input.
- After reset deasserts, history holds zeros, so an early L1A matches nothing.

## Test plan
- `lct`=0x05 at cycle 1000, `l1a` at 1100 (defaults) → at 1101: `l1a_out`=1, `l1a_match`=0x05, `l1a_cnt`=1.
- Window edges: `lct[3]` at 1000, then `l1a` at 1099, 1101, 1098 and 1102 in separate runs → match bit 3 set for 1099 and 1101; 0x00 for 1098 and 1102.
- `l1a` at 500, `alct_dav` at 530, no `tmb_dav` → no ALCT flag; `tmb_timeout` pulse at cycle 565.
- `tmb_dav` with no prior L1A → `tmb_unexp` pulse the next cycle. `l1a` at 200 and again at 210 with no DAV between → `alct_overlap` and `tmb_overlap` at 211, and the timeout is re-timed from 210.
- Preload `l1a_cnt` to 0xFFFFFE (force, or 16M L1As), then 3 L1As → `l1a_cnt` reads 0xFFFFFF, 0x000000, 0x000001.
- Assert `rst` while both FSMs are in WAIT → no timeout ever fires. All outputs are 0 the cycle after reset, and the history is empty (an L1A 100 cycles after a pre-reset LCT gives match 0x00).
